neuron_activation: RTL and testbench

- Downstream stage of the 8x8 signed MAC. Consumes the MAC's running 16-bit signed accumulator over N_INPUTS beats and captures the final sum.
- Adds a signed bias, rescales by an arithmetic right shift, applies ReLU and saturates to a signed 8-bit activation.
- Presents the activation to the next layer over a valid/ready handshake.
- Pulses mac_clear so the accumulator restarts for the next neuron evaluation.

---
 rtl/neuron_activation.sv | 133 +++++++++++++
 tb/tb_neuron_activation.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/neuron_activation.sv
// neuron_activation: captures the final MAC accumulator of a neuron evaluation,
// adds a bias, rescales by an arithmetic right shift, applies ReLU with
// saturation to 0..127 and hands the result downstream over valid/ready.
//
// state   | meaning
// --------+---------------------------------------------------------------
// ACCUM   | accepting MAC beats; the final beat latches sum/bias/shift
// COMPUTE | one cycle: bias add, shift, ReLU/saturate; mac_clear is high
// OUTPUT  | y_valid high, result held until y_ready
module neuron_activation #(
   parameter int N_INPUTS = 4,
   parameter int CNT_W    = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] acc_in,
   input  logic        acc_valid,
   output logic        acc_ready,
   input  logic [15:0] bias,
   input  logic [3:0]  shift,
   output logic        mac_clear,
   output logic [7:0]  y_out,
   output logic        y_valid,
   output logic        y_sat,
   input  logic        y_ready
);

   typedef enum logic [1:0] {
      ACCUM   = 2'd0,
      COMPUTE = 2'd1,
      OUTPUT  = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_INPUTS - 1);

   state_t state;
   state_t state_nxt;

   logic [CNT_W-1:0] count;
   logic [15:0]      sum_r;
   logic [15:0]      bias_r;
   logic [3:0]       shift_r;

   logic             beat;
   logic             last_beat;

   logic signed [16:0] t_sum;
   logic signed [16:0] u_shr;
   logic [7:0]         y_nxt;
   logic               sat_nxt;

   assign acc_ready = (state == ACCUM);
   assign beat      = acc_valid && acc_ready;
   assign last_beat = beat && (count == LAST_CNT);

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ACCUM;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         ACCUM:   if (last_beat) state_nxt = COMPUTE;
         COMPUTE: state_nxt = OUTPUT;
         OUTPUT:  if (y_ready) state_nxt = ACCUM;
         default: state_nxt = ACCUM;
      endcase
   end

   // Beat counter; wraps to zero on the final beat so it never passes N_INPUTS-1
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (last_beat) begin
         count <= '0;
      end else if (beat) begin
         count <= count + 1'b1;
      end
   end

   // Capture final sum and its bias/shift; mac_clear follows the final beat by one cycle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sum_r     <= '0;
         bias_r    <= '0;
         shift_r   <= '0;
         mac_clear <= 1'b0;
      end else begin
         mac_clear <= last_beat;
         if (last_beat) begin
            sum_r   <= acc_in;
            bias_r  <= bias;
            shift_r <= shift;
         end
      end
   end

   // Bias add in 17 bits (cannot overflow), floor shift, then ReLU and clip at 127
   always_comb begin
      t_sum   = $signed({sum_r[15], sum_r}) + $signed({bias_r[15], bias_r});
      u_shr   = t_sum >>> shift_r;
      y_nxt   = u_shr[7:0];
      sat_nxt = 1'b0;
      if (u_shr[16]) begin
         y_nxt = 8'd0;
      end else if (|u_shr[15:7]) begin
         y_nxt   = 8'd127;
         sat_nxt = 1'b1;
      end
   end

   // Output register: loaded in COMPUTE, held through backpressure
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         y_out   <= '0;
         y_sat   <= 1'b0;
         y_valid <= 1'b0;
      end else if (state == COMPUTE) begin
         y_out   <= y_nxt;
         y_sat   <= sat_nxt;
         y_valid <= 1'b1;
      end else if ((state == OUTPUT) && y_ready) begin
         y_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_neuron_activation.sv
// Bench for neuron_activation: directed cases plus randomized evaluations,
// checked against an arithmetic reference of bias/shift/ReLU/saturate.
module tb_neuron_activation;

   localparam int N = 4;

   logic        clk;
   logic        rst_n;
   logic [15:0] acc_in;
   logic        acc_valid;
   logic        acc_ready;
   logic [15:0] bias;
   logic [3:0]  shift;
   logic        mac_clear;
   logic [7:0]  y_out;
   logic        y_valid;
   logic        y_sat;
   logic        y_ready;

   int total  = 0;
   int passed = 0;
   int failed = 0;
   int clr_cnt = 0;

   neuron_activation #(.N_INPUTS(N), .CNT_W(8)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .acc_in    (acc_in),
      .acc_valid (acc_valid),
      .acc_ready (acc_ready),
      .bias      (bias),
      .shift     (shift),
      .mac_clear (mac_clear),
      .y_out     (y_out),
      .y_valid   (y_valid),
      .y_sat     (y_sat),
      .y_ready   (y_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Count mac_clear pulses (one negedge per high cycle)
   always @(negedge clk) if (mac_clear === 1'b1) clr_cnt++;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
      total++;
      assert (obs === exp) begin
         passed++;
      end else begin
         failed++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Reference: floor((acc+bias)/2^sh), ReLU, clip at 127
   function automatic int ref_y(input int fin, input int b, input int sh, output bit sat);
      int t;
      int d;
      int u;
      t   = fin + b;
      d   = 1 << sh;
      u   = (t >= 0) ? (t / d) : -((-t + d - 1) / d);
      sat = 1'b0;
      if (u < 0) return 0;
      if (u > 127) begin
         sat = 1'b1;
         return 127;
      end
      return u;
   endfunction

   task automatic send_beat(input int v, input int b, input int sh);
      int n;
      acc_valid = 1'b1;
      acc_in    = 16'(v);
      bias      = 16'(b);
      shift     = 4'(sh);
      n = 0;
      while (!acc_ready && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      if (n >= 50) chk("beat_timeout", 0, 1);
      @(posedge clk); #1;
      acc_valid = 1'b0;
      acc_in    = 16'($urandom);
      bias      = 16'($urandom);
      shift     = 4'($urandom);
   endtask

   // One evaluation: N-1 random beats, then the final beat carrying bias/shift
   task automatic do_eval(input int fin, input int b, input int sh, input bit hold);
      int ey;
      bit es;
      int c0;
      ey = ref_y(fin, b, sh, es);
      c0 = clr_cnt;
      for (int i = 0; i < N - 1; i++) begin
         send_beat(int'($urandom_range(0, 65535)), int'($urandom_range(0, 65535)),
                   int'($urandom_range(0, 15)));
         chk("no_early_valid", y_valid, 0);
         chk("no_early_clear", mac_clear, 0);
      end
      send_beat(fin, b, sh);
      chk("clear_after_final", mac_clear, 1);
      chk("not_ready_compute", acc_ready, 0);
      chk("valid_low_compute", y_valid, 0);
      @(posedge clk); #1;
      chk("clear_one_cycle", mac_clear, 0);
      chk("valid_rise", y_valid, 1);
      chk("y_out", y_out, ey);
      chk("y_sat", y_sat, es);
      chk("clear_count", clr_cnt, c0 + 1);
      if (!hold) begin
         @(posedge clk); #1;
         chk("valid_drop", y_valid, 0);
         chk("ready_again", acc_ready, 1);
      end
   endtask

   initial begin
      logic [7:0] yo;
      logic       ys;
      int c0;
      int f;
      int b;
      int s;

      rst_n     = 1'b0;
      acc_in    = '0;
      acc_valid = 1'b0;
      bias      = '0;
      shift     = '0;
      y_ready   = 1'b1;
      #3;
      chk("rst_y_valid", y_valid, 0);
      chk("rst_y_out", y_out, 0);
      chk("rst_y_sat", y_sat, 0);
      chk("rst_mac_clear", mac_clear, 0);
      chk("rst_acc_ready", acc_ready, 1);
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;

      // Basic capture and saturation, exact fit, bias subtract
      do_eval(4102, 0, 5, 1'b0);
      do_eval(1000, 16, 3, 1'b0);
      do_eval(100, -40, 0, 1'b0);

      // Reset mid-operation after two beats
      send_beat(11, 0, 0);
      send_beat(22, 0, 0);
      #3 rst_n = 1'b0;
      #1;
      chk("mid_rst_y_out", y_out, 0);
      chk("mid_rst_y_valid", y_valid, 0);
      chk("mid_rst_y_sat", y_sat, 0);
      chk("mid_rst_clear", mac_clear, 0);
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      do_eval(500, 20, 2, 1'b0);

      // ReLU and floor toward -inf
      do_eval(-16129, 0, 0, 1'b0);
      do_eval(3, -4, 1, 1'b0);

      // Backpressure: result held, beats ignored
      y_ready = 1'b0;
      do_eval(777, -100, 3, 1'b1);
      yo = y_out;
      ys = y_sat;
      for (int i = 0; i < 5; i++) begin
         acc_valid = 1'($urandom_range(0, 1));
         acc_in    = 16'($urandom);
         @(posedge clk); #1;
         chk("bp_y_out", y_out, yo);
         chk("bp_y_sat", y_sat, ys);
         chk("bp_acc_ready", acc_ready, 0);
         chk("bp_y_valid", y_valid, 1);
      end
      acc_valid = 1'b0;
      y_ready   = 1'b1;
      @(posedge clk); #1;
      chk("bp_release", y_valid, 0);
      c0 = clr_cnt;
      do_eval(9000, 50, 6, 1'b0);
      chk("bp_one_result", clr_cnt, c0 + 1);

      // Extremes
      do_eval(-32768, -32768, 15, 1'b0);
      do_eval(32767, 32767, 15, 1'b0);
      do_eval(200, -200, 0, 1'b0);

      // Randomized evaluations
      for (int k = 0; k < 16; k++) begin
         f = int'($urandom_range(0, 65535)) - 32768;
         b = int'($urandom_range(0, 65535)) - 32768;
         s = int'($urandom_range(0, 15));
         if (k % 4 == 0) s = int'($urandom_range(0, 3));
         do_eval(f, b, s, 1'b0);
         repeat (int'($urandom_range(0, 2))) @(posedge clk);
         #1;
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
